// File: rtl/frac_div_ctrl.sv
// Dual-modulus fractional clock-divider scheduler: average output period N + K/D input clocks.
// Defining FRAC_DIV_PCNT_EN adds the 16-bit completed-period counter port period_cnt.
module frac_div_ctrl #(
    parameter int NW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [NW-1:0] cfg_int,
    input  logic [DW-1:0] cfg_num,
    input  logic [DW-1:0] cfg_den,
    output logic          cfg_err,
    output logic          clk_out,
    output logic          period_start,
    output logic          sel_long,
`ifdef FRAC_DIV_PCNT_EN
    output logic [15:0]   period_cnt,
`endif
    output logic          busy
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [NW-1:0] act_int, shd_int, int_eff;
    logic [DW-1:0] act_num, shd_num, num_eff;
    logic [DW-1:0] act_den, shd_den, den_eff;
    logic [DW-1:0] acc, acc_eff, acc_nxt;
    logic          pending;
    logic [NW:0]   phase, phase_inc, p_len, p_new;
    logic [DW:0]   sum;
    logic          long_nxt, last, start_now, end_now, apply, accept, legal;

    function automatic logic cfg_legal(input logic [NW-1:0] n, input logic [DW-1:0] k,
                                       input logic [DW-1:0] d);
        return (n >= NW'(2)) && (n != {NW{1'b1}}) && (d != '0) && (k < d);
    endfunction

    assign cfg_ready = ~pending;
    assign busy      = (state == RUN);
    assign accept    = cfg_valid & cfg_ready;
    assign legal     = cfg_legal(cfg_int, cfg_num, cfg_den);
    assign phase_inc = phase + (NW+1)'(1);
    assign last      = (phase == p_len - (NW+1)'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Period scheduling: a pending config replaces the active one (and zeroes acc) at apply time.
    always_comb begin
        state_nxt = state;
        start_now = 1'b0;
        end_now   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = RUN;
                    start_now = 1'b1;
                end
            end
            RUN: begin
                if (last) begin
                    end_now = 1'b1;
                    if (enable) start_now = 1'b1;
                    else        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        apply    = pending & ((state == IDLE) | start_now);
        int_eff  = apply ? shd_int : act_int;
        num_eff  = apply ? shd_num : act_num;
        den_eff  = apply ? shd_den : act_den;
        acc_eff  = apply ? '0 : acc;
        sum      = {1'b0, acc_eff} + {1'b0, num_eff};
        long_nxt = (sum >= {1'b0, den_eff});
        acc_nxt  = long_nxt ? DW'(sum - {1'b0, den_eff}) : sum[DW-1:0];
        p_new    = {1'b0, int_eff} + (NW+1)'(long_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_int      <= NW'(2);
            act_num      <= '0;
            act_den      <= DW'(1);
            shd_int      <= NW'(2);
            shd_num      <= '0;
            shd_den      <= DW'(1);
            pending      <= 1'b0;
            acc          <= '0;
            phase        <= '0;
            p_len        <= (NW+1)'(2);
            cfg_err      <= 1'b0;
            clk_out      <= 1'b0;
            period_start <= 1'b0;
            sel_long     <= 1'b0;
        end else begin
            cfg_err <= accept & ~legal;
            if (accept & legal) begin
                shd_int <= cfg_int;
                shd_num <= cfg_num;
                shd_den <= cfg_den;
                pending <= 1'b1;
            end
            if (apply) begin
                act_int <= shd_int;
                act_num <= shd_num;
                act_den <= shd_den;
                pending <= 1'b0;
                acc     <= '0;
            end
            if (start_now) begin
                acc          <= acc_nxt;
                p_len        <= p_new;
                phase        <= '0;
                period_start <= 1'b1;
                sel_long     <= long_nxt;
                clk_out      <= 1'b1;
            end else if (end_now || state == IDLE) begin
                phase        <= '0;
                period_start <= 1'b0;
                sel_long     <= 1'b0;
                clk_out      <= 1'b0;
            end else begin
                phase        <= phase_inc;
                period_start <= 1'b0;
                clk_out      <= (phase_inc < (p_len >> 1));
            end
        end
    end

`ifdef FRAC_DIV_PCNT_EN
    always_ff @(posedge clk) begin
        if (rst)          period_cnt <= '0;
        else if (end_now) period_cnt <= period_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_frac_div_ctrl.sv
// Self-checking bench for frac_div_ctrl: legality table, period scoreboard, handshake/enable/reset corners.
module tb_frac_div_ctrl;

    logic       clk = 1'b0;
    logic       rst, enable, cfg_valid;
    logic       cfg_ready, cfg_err, clk_out, period_start, sel_long, busy;
    logic [7:0] cfg_int, cfg_num, cfg_den;
`ifdef FRAC_DIV_PCNT_EN
    logic [15:0] period_cnt;
`endif

    frac_div_ctrl #(.NW(8), .DW(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_int(cfg_int), .cfg_num(cfg_num), .cfg_den(cfg_den), .cfg_err(cfg_err),
        .clk_out(clk_out), .period_start(period_start), .sel_long(sel_long),
`ifdef FRAC_DIV_PCNT_EN
        .period_cnt(period_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int n; int k; int d; int err; int rdy; } vec_t;
    typedef struct { int len; int lng; } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_acc;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int len, input int lng);
        exp_t e;
        e.len = len;
        e.lng = lng;
        exp_q.push_back(e);
    endtask

    // accumulator reference for N + K/D, continuing from m_acc
    task automatic push_model(input int n, input int k, input int d, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int s;
            s = m_acc + k;
            if (s >= d) begin push(n + 1, 1); m_acc = s - d; end
            else        begin push(n, 0);     m_acc = s;     end
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_clk_out"}, clk_out, 0);
        check({tag, "_pstart"}, period_start, 0);
        check({tag, "_sel_long"}, sel_long, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cfg_err"}, cfg_err, 0);
        check({tag, "_cfg_ready"}, cfg_ready, 1);
`ifdef FRAC_DIV_PCNT_EN
        check({tag, "_pcnt"}, period_cnt, 0);
`endif
    endtask

    task automatic offer(input int n, input int k, input int d, output int err, output int rdy);
        int g;
        cfg_valid = 1'b1;
        cfg_int = 8'(n);
        cfg_num = 8'(k);
        cfg_den = 8'(d);
        g = 0;
        while (!cfg_ready && g < 50) begin @(negedge clk); g++; end
        if (!cfg_ready) check("offer_timeout", 0, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        err = cfg_err;
        rdy = cfg_ready;
    endtask

    // Measure one period starting at a period_start cycle and compare with the queue head
    task automatic per();
        int   len, hi, g, stable, lng;
        int   pc0;
        exp_t e;
        g = 0;
        while (!period_start && g < 50) begin @(negedge clk); g++; end
        if (!period_start) begin
            check("period_start_timeout", 0, 1);
            return;
        end
        pc0 = 0;
`ifdef FRAC_DIV_PCNT_EN
        pc0 = period_cnt;
`endif
        len = 0; hi = 0; stable = 1; lng = sel_long;
        do begin
            len++;
            hi += clk_out;
            if (sel_long != lng[0]) stable = 0;
            @(negedge clk);
        end while (!period_start && busy && len < 100);
        if (exp_q.size() == 0) begin
            check("queue_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check("period_len", len, e.len);
        check("sel_long", lng, e.lng);
        check("clk_high_cycles", hi, e.len >> 1);
        check("sel_long_held", stable, 1);
`ifdef FRAC_DIV_PCNT_EN
        if (period_start) check("pcnt_inc", period_cnt, (pc0 + 1) & 16'hFFFF);
`endif
    endtask

    initial begin
        vec_t tbl[6];
        int   exp1[10];
        int   err, rdy, len, bad, g;

        tbl[0] = '{n: 1,   k: 0, d: 1, err: 1, rdy: 1};
        tbl[1] = '{n: 5,   k: 0, d: 0, err: 1, rdy: 1};
        tbl[2] = '{n: 5,   k: 7, d: 7, err: 1, rdy: 1};
        tbl[3] = '{n: 255, k: 0, d: 1, err: 1, rdy: 1};
        tbl[4] = '{n: 4,   k: 0, d: 1, err: 0, rdy: 0};
        tbl[5] = '{n: 3,   k: 5, d: 4, err: 1, rdy: 1};
        exp1   = '{5, 5, 5, 6, 5, 5, 6, 5, 5, 6};

        rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
        cfg_int = 8'd0; cfg_num = 8'd0; cfg_den = 8'd0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Legality table; only {4,0,1} is stored and applied while idle
        for (int i = 0; i < 6; i++) begin
            offer(tbl[i].n, tbl[i].k, tbl[i].d, err, rdy);
            check($sformatf("cfg_err_%0d", i), err, tbl[i].err);
            check($sformatf("cfg_ready_after_%0d", i), rdy, tbl[i].rdy);
            @(negedge clk);
            check($sformatf("cfg_err_pulse_%0d", i), cfg_err, 0);
            check($sformatf("cfg_ready_settled_%0d", i), cfg_ready, 1);
        end

        // N=4 integer division; first period one cycle after enable
        enable = 1'b1;
        @(negedge clk);
        check("t2_first_pstart", period_start, 1);
        check("t2_busy", busy, 1);
        for (int i = 0; i < 5; i++) push(4, 0);
        for (int i = 0; i < 5; i++) per();
        enable = 1'b0;
        g = 0;
        while (busy && g < 20) begin @(negedge clk); g++; end
        check("t2_idle", busy, 0);
        check("t2_idle_clk", clk_out, 0);

        // N=5, K=3, D=10: long periods 4, 7, 10 repeating
        offer(5, 3, 10, err, rdy);
        check("t1_cfg_err", err, 0);
        repeat (2) @(negedge clk);
        enable = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 10; i++) push(exp1[i], (exp1[i] == 6) ? 1 : 0);
        for (int i = 0; i < 20; i++) per();

        // Mid-run reconfig to N=8, then a second offer held while pending
        check("t4_at_pstart", period_start, 1);
        cfg_valid = 1'b1; cfg_int = 8'd8; cfg_num = 8'd0; cfg_den = 8'd1;
        @(negedge clk);
        check("t4_ready_low", cfg_ready, 0);
        cfg_int = 8'd6;
        len = 1; bad = 0;
        while (!period_start && len < 20) begin
            if (cfg_ready) bad++;
            @(negedge clk);
            len++;
        end
        check("t4_old_period_len", len, 5);
        check("t4_ready_low_whole_period", bad, 0);
        check("t4_ready_at_apply", cfg_ready, 1);
        @(negedge clk);
        check("t4_second_accepted", cfg_ready, 0);
        cfg_valid = 1'b0;
        len = 2;
        while (!period_start && len < 30) begin @(negedge clk); len++; end
        check("t4_n8_period_len", len - 1, 8);
        push(6, 0);
        per();
        enable = 1'b0;
        g = 0;
        while (busy && g < 20) begin @(negedge clk); g++; end
        check("t4_idle", busy, 0);

        // Enable dropped at phase 1 of a long period; re-enable continues acc
        offer(5, 3, 10, err, rdy);
        check("t5_cfg_err", err, 0);
        check("t5_cfg_pending", rdy, 0);
        repeat (2) @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) push(5, 0);
        for (int i = 0; i < 3; i++) per();
        check("t5_long_start", period_start, 1);
        check("t5_long_sel", sel_long, 1);
        len = 1;
        @(negedge clk);
        len = 2;
        enable = 1'b0;
        while (busy && len < 30) begin @(negedge clk); len++; end
        check("t5_drop_period_len", len - 1, 6);
        check("t5_idle_clk", clk_out, 0);
        check("t5_idle_pstart", period_start, 0);
        repeat (3) @(negedge clk);
        check("t5_idle_hold", busy, 0);
        m_acc = 2;
        push_model(5, 3, 10, 6);
        enable = 1'b1;
        @(negedge clk);
        check("t5_reenable_pstart", period_start, 1);
        for (int i = 0; i < 6; i++) per();

        // Reset at phase 3 with a pending config
        cfg_valid = 1'b1; cfg_int = 8'd7; cfg_num = 8'd0; cfg_den = 8'd1;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("t6_pending", cfg_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check_reset("t6");
        rst = 1'b0;
        @(negedge clk);
        check("t6_pending_dropped", cfg_ready, 1);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) push(2, 0);
        for (int i = 0; i < 3; i++) per();
        enable = 1'b0;
        repeat (4) @(negedge clk);
        check("final_queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
